// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined flag-producing ALU:
// opcode encoding and the bit positions inside the 5-bit flag vector.
`timescale 1ns/1ps
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SRA = 3'd5,
        OP_SLL = 3'd6,
        OP_CMP = 3'd7
    } alu_op_e;

    localparam int FLAG_V = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_P = 0;
    localparam int FLAG_W = 5;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag packer: takes the final (possibly clamped) result plus
// the V and C bits from the arithmetic stage and returns {V, C, N, Z, P}.
`timescale 1ns/1ps
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]      result_i,
    input  logic              v_i,
    input  logic              c_i,
    output logic [FLAG_W-1:0] flags_o
);

    // N, Z and P describe the delivered result; V and C pass straight through
    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_V] = v_i;
        flags_o[FLAG_C] = c_i;
        flags_o[FLAG_N] = result_i[N-1];
        flags_o[FLAG_Z] = (result_i == '0);
        flags_o[FLAG_P] = ~^result_i;
    end

endmodule

// File: rtl/alu_flags_pipe.sv
// Two-stage pipelined signed ALU with {V,C,N,Z,P} flags, valid/ready flow
// control, pass-through tag and a sticky overflow bit.
// Stage 1 registers the command; stage 2 computes result and flags and
// registers them onto the outputs. Both stages freeze while the output is
// valid but not accepted.
// Optional feature: define ALU_SAT_EN to clamp ADD/SUB overflow results to
// the signed range (CMP is never clamped).
`timescale 1ns/1ps
module alu_flags_pipe
    import alu_pkg::*;
#(
    parameter int N     = 16,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [N-1:0]      in_a,
    input  logic [N-1:0]      in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_result,
    output logic [FLAG_W-1:0] out_flags,
    output logic [TAG_W-1:0]  out_tag,
    output logic              sticky_v,
    input  logic              clr_sticky
);

    localparam int SH_W = $clog2(N);

    logic stall;

    // stage 1 (command) registers
    logic             s1_valid_q, s1_valid_d;
    alu_op_e          s1_op_q,    s1_op_d;
    logic [N-1:0]     s1_a_q,     s1_a_d;
    logic [N-1:0]     s1_b_q,     s1_b_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    // stage 2 (output) registers
    logic              out_valid_q,  out_valid_d;
    logic [N-1:0]      out_result_q, out_result_d;
    logic [FLAG_W-1:0] out_flags_q,  out_flags_d;
    logic [TAG_W-1:0]  out_tag_q,    out_tag_d;
    logic              s2_vhit_q,    s2_vhit_d;
    logic              sticky_q,     sticky_d;

    // stage 2 datapath
    logic [SH_W-1:0]   sh_amt;
    logic [N:0]        add_wide;
    logic [N:0]        sub_wide;
    logic signed [N:0] sra_wide;
    logic [N:0]        sll_wide;
    logic [N-1:0]      res_raw;
    logic [N-1:0]      res_final;
    logic              v_bit;
    logic              c_bit;
    logic              is_addsub;
    logic [FLAG_W-1:0] flags_calc;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign out_tag    = out_tag_q;
    assign sticky_v   = sticky_q;

    // Stage 1 next state: take a new command (or a bubble) unless stalled
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        if (!stall) begin
            s1_valid_d = in_valid;
            s1_op_d    = alu_op_e'(in_op);
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_tag_d   = in_tag;
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_ADD;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_tag_q   <= s1_tag_d;
        end
    end

    // All arithmetic runs one bit wider so carry/borrow and the last
    // shifted-out bit fall out of the top/bottom bit of the wide value
    assign sh_amt   = s1_b_q[SH_W-1:0];
    assign add_wide = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign sub_wide = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + {{N{1'b0}}, 1'b1};
    assign sra_wide = $signed({s1_a_q, 1'b0}) >>> sh_amt;
    assign sll_wide = {1'b0, s1_a_q} << sh_amt;

    // Stage 2 result, overflow and carry/borrow selection per opcode
    always_comb begin
        res_raw   = '0;
        v_bit     = 1'b0;
        c_bit     = 1'b0;
        is_addsub = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                res_raw   = add_wide[N-1:0];
                v_bit     = (s1_a_q[N-1] == s1_b_q[N-1]) && (add_wide[N-1] != s1_a_q[N-1]);
                c_bit     = add_wide[N];
                is_addsub = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                res_raw   = sub_wide[N-1:0];
                v_bit     = (s1_a_q[N-1] != s1_b_q[N-1]) && (sub_wide[N-1] != s1_a_q[N-1]);
                // no carry out of A + ~B + 1 means A < B unsigned
                c_bit     = ~sub_wide[N];
                is_addsub = (s1_op_q == OP_SUB);
            end
            OP_AND: res_raw = s1_a_q & s1_b_q;
            OP_OR:  res_raw = s1_a_q | s1_b_q;
            OP_XOR: res_raw = s1_a_q ^ s1_b_q;
            OP_SRA: begin
                res_raw = sra_wide[N:1];
                c_bit   = sra_wide[0];
            end
            OP_SLL: begin
                res_raw = sll_wide[N-1:0];
                c_bit   = sll_wide[N];
            end
            default: res_raw = '0;
        endcase
    end

    // Optional clamp of ADD/SUB overflow; A's sign tells the overflow direction
    always_comb begin
`ifdef ALU_SAT_EN
        if (is_addsub && v_bit)
            res_final = s1_a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        else
            res_final = res_raw;
`else
        res_final = res_raw;
`endif
    end

    alu_flag_gen #(.N(N)) u_flag_gen (
        .result_i (res_final),
        .v_i      (v_bit),
        .c_i      (c_bit),
        .flags_o  (flags_calc)
    );

    // Stage 2 next state: advance stage 1 into the outputs unless stalled
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        out_tag_d    = out_tag_q;
        s2_vhit_d    = s2_vhit_q;
        if (!stall) begin
            out_valid_d  = s1_valid_q;
            out_result_d = res_final;
            out_flags_d  = flags_calc;
            out_tag_d    = s1_tag_q;
            s2_vhit_d    = is_addsub & v_bit;
        end
    end

    // Sticky overflow: a handed-off ADD/SUB overflow beats a same-cycle clear
    always_comb begin
        sticky_d = (out_valid_q & out_ready & s2_vhit_q) | (sticky_q & ~clr_sticky);
    end

    // Stage 2 and sticky registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            out_tag_q    <= '0;
            s2_vhit_q    <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            out_tag_q    <= out_tag_d;
            s2_vhit_q    <= s2_vhit_d;
            sticky_q     <= sticky_d;
        end
    end

endmodule

// File: tb/tb_alu_flags_pipe.sv
// Self-checking bench for alu_flags_pipe: directed vectors, backpressure,
// random traffic against a behavioural integer model, and mid-flight reset.
`timescale 1ns/1ps
module tb_alu_flags_pipe;

    localparam int N     = 16;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [N-1:0]     res;
        logic [4:0]       flags;
        logic [TAG_W-1:0] tag;
        logic             vhit;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [N-1:0]     in_a = '0;
    logic [N-1:0]     in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [N-1:0]     out_result;
    logic [4:0]       out_flags;
    logic [TAG_W-1:0] out_tag;
    logic             sticky_v;
    logic             clr_sticky = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_flags_pipe #(.N(N), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_tag    (out_tag),
        .sticky_v   (sticky_v),
        .clr_sticky (clr_sticky)
    );

    // Behavioural model: exact signed/unsigned integer arithmetic, then range checks
    function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] a,
                                   input logic [N-1:0] b, input logic [TAG_W-1:0] tag);
        exp_t        e;
        longint      sa, sb, ua, ub, t, lim_hi, lim_lo;
        int          sh;
        logic        v, c;
        logic [63:0] r64;
        logic [N-1:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        lim_hi = (longint'(1) <<< (N-1)) - 1;
        lim_lo = -(longint'(1) <<< (N-1));
        sh = int'(ub % N);
        v = 1'b0; c = 1'b0; t = 0;
        case (op)
            3'd0: begin
                t = sa + sb;
                v = (t > lim_hi) || (t < lim_lo);
                c = (ua + ub) >= (longint'(1) <<< N);
            end
            3'd1, 3'd7: begin
                t = sa - sb;
                v = (t > lim_hi) || (t < lim_lo);
                c = ua < ub;
            end
            3'd2: t = ua & ub;
            3'd3: t = ua | ub;
            3'd4: t = ua ^ ub;
            3'd5: begin
                t = sa >>> sh;
                c = (sh != 0) && (((ua >> (sh - 1)) % 2) == 1);
            end
            default: begin
                t = ua << sh;
                c = (sh != 0) && (((ua >> (N - sh)) % 2) == 1);
            end
        endcase
        r64 = t;
`ifdef ALU_SAT_EN
        if ((op == 3'd0 || op == 3'd1) && v)
            r64 = (t > lim_hi) ? lim_hi : lim_lo;
`endif
        res = r64[N-1:0];
        e.res   = res;
        e.flags = {v, c, res[N-1], (res == 0), (($countones(res) % 2) == 0)};
        e.tag   = tag;
        e.vhit  = (op == 3'd0 || op == 3'd1) && v;
        return e;
    endfunction

    // one idle cycle with clr_sticky pulsed (no checking)
    task automatic pulse_clear();
        @(negedge clk);
        in_valid   = 1'b0;
        clr_sticky = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_sticky = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_result !== '0 || out_flags !== '0 ||
            out_tag !== '0 || sticky_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b res=%h flags=%b tag=%h sticky=%b, expected all zero",
                     out_valid, out_result, out_flags, out_tag, sticky_v);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [2:0]   ops [5];
        logic [N-1:0] as  [5];
        logic [N-1:0] bs  [5];
        logic [N-1:0] er  [5];
        logic [4:0]   ef  [5];
        logic         clr [5];
        logic         est [5];
        ops = '{3'd1, 3'd1, 3'd0, 3'd5, 3'd7};
        as  = '{16'd20000, 16'd5, 16'hFFFF, 16'h8000, 16'd20000};
        bs  = '{16'hB1E0, 16'd5, 16'h0001, 16'd4, 16'hB1E0};
`ifdef ALU_SAT_EN
        er  = '{16'h7FFF, 16'h0000, 16'h0000, 16'hF800, 16'h9C40};
        ef  = '{5'b11000, 5'b00011, 5'b01011, 5'b00100, 5'b11100};
`else
        er  = '{16'h9C40, 16'h0000, 16'h0000, 16'hF800, 16'h9C40};
        ef  = '{5'b11100, 5'b00011, 5'b01011, 5'b00100, 5'b11100};
`endif
        clr = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        est = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            if (clr[i]) pulse_clear();
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_op     = ops[i];
            in_a      = as[i];
            in_b      = bs[i];
            in_tag    = TAG_W'(i + 5);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL latency_early[%0d]: out_valid got %b expected 0", i, out_valid);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_result !== er[i] || out_flags !== ef[i] ||
                out_tag !== TAG_W'(i + 5)) begin
                errors++;
                $display("FAIL directed[%0d]: got valid=%b res=%h flags=%b tag=%h expected valid=1 res=%h flags=%b tag=%h",
                         i, out_valid, out_result, out_flags, out_tag, er[i], ef[i], TAG_W'(i + 5));
            end
            @(negedge clk);
            checks++;
            if (sticky_v !== est[i]) begin
                errors++;
                $display("FAIL directed_sticky[%0d]: got %b expected %b", i, sticky_v, est[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e1, e2, e3;
        logic [N-1:0] b2;
        b2 = N'($urandom);
        e1 = model(3'd1, 16'd20000, 16'hB1E0, 4'd1);
        e2 = model(3'd0, 16'h1234, b2, 4'd2);
        e3 = model(3'd4, 16'hA5A5, 16'h0FF0, 4'd3);
        pulse_clear();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd1; in_a = 16'd20000; in_b = 16'hB1E0; in_tag = 4'd1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept1: in_ready got %b expected 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_op = 3'd0; in_a = 16'h1234; in_b = b2; in_tag = 4'd2;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept2: in_ready got %b expected 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_op = 3'd4; in_a = 16'hA5A5; in_b = 16'h0FF0; in_tag = 4'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'd1 ||
                out_result !== e1.res || out_flags !== e1.flags) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ready=%b valid=%b tag=%h res=%h flags=%b expected ready=0 valid=1 tag=1 res=%h flags=%b",
                         i, in_ready, out_valid, out_tag, out_result, out_flags, e1.res, e1.flags);
            end
            @(posedge clk);
            @(negedge clk);
        end
        // release: tag1 handed off with a simultaneous sticky clear, tag3 taken
        out_ready  = 1'b1;
        clr_sticky = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready got %b expected 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        clr_sticky = 1'b0;
        in_valid   = 1'b0;
        checks++;
        if (sticky_v !== 1'b1) begin errors++; $display("FAIL bp_sticky_set_wins: got %b expected 1", sticky_v); end
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'd2 || out_result !== e2.res || out_flags !== e2.flags) begin
            errors++;
            $display("FAIL bp_tag2: got valid=%b tag=%h res=%h flags=%b expected tag=2 res=%h flags=%b",
                     out_valid, out_tag, out_result, out_flags, e2.res, e2.flags);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'd3 || out_result !== e3.res || out_flags !== e3.flags) begin
            errors++;
            $display("FAIL bp_tag3: got valid=%b tag=%h res=%h flags=%b expected tag=3 res=%h flags=%b",
                     out_valid, out_tag, out_result, out_flags, e3.res, e3.flags);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: out_valid got %b expected 0", out_valid); end
    endtask

    task automatic test_random();
        exp_t         q[$];
        exp_t         e;
        logic         sticky_exp;
        logic         hand, acc, acc_last;
        logic [N-1:0] corner[4];
        int           cyc;
        corner = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
        pulse_clear();
        sticky_exp = 1'b0;
        acc_last   = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            checks++;
            if (sticky_v !== sticky_exp) begin
                errors++;
                $display("FAIL rnd_sticky[%0d]: got %b expected %b", i, sticky_v, sticky_exp);
            end
            if (!in_valid || acc_last) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_op    = 3'($urandom);
                in_a     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : N'($urandom);
                in_b     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : N'($urandom);
                in_tag   = TAG_W'($urandom);
            end
            out_ready  = ($urandom_range(0, 3) != 0);
            clr_sticky = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL rnd_in_ready[%0d]: got %b with out_valid=%b out_ready=%b", i, in_ready, out_valid, out_ready);
            end
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious[%0d]: out_valid=1 with nothing outstanding, tag=%h", i, out_tag);
                end else if (out_result !== q[0].res || out_flags !== q[0].flags || out_tag !== q[0].tag) begin
                    errors++;
                    $display("FAIL rnd_result[%0d]: got res=%h flags=%b tag=%h expected res=%h flags=%b tag=%h",
                             i, out_result, out_flags, out_tag, q[0].res, q[0].flags, q[0].tag);
                end
            end
            hand = out_valid && out_ready;
            acc  = in_valid && in_ready;
            if (hand && q.size() > 0) begin
                e = q.pop_front();
                if (e.vhit) sticky_exp = 1'b1;
                else if (clr_sticky) sticky_exp = 1'b0;
            end else if (clr_sticky) begin
                sticky_exp = 1'b0;
            end
            if (acc) q.push_back(model(in_op, in_a, in_b, in_tag));
            acc_last = acc;
            @(posedge clk);
        end
        // drain with a bounded wait
        @(negedge clk);
        in_valid   = 1'b0;
        clr_sticky = 1'b0;
        out_ready  = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            #1;
            if (out_valid) begin
                checks++;
                if (out_result !== q[0].res || out_flags !== q[0].flags || out_tag !== q[0].tag) begin
                    errors++;
                    $display("FAIL rnd_drain: got res=%h flags=%b tag=%h expected res=%h flags=%b tag=%h",
                             out_result, out_flags, out_tag, q[0].res, q[0].flags, q[0].tag);
                end
                void'(q.pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain_timeout: %0d results still outstanding, expected 0", q.size());
        end
    endtask

    task automatic test_async_reset();
        // load an overflowing ADD so sticky is set, then fill both stages
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 3'd0; in_a = 16'h7FFF; in_b = 16'h0001; in_tag = 4'hA;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (sticky_v !== 1'b1) begin errors++; $display("FAIL rst_pre_sticky: got %b expected 1", sticky_v); end
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd2; in_a = 16'h00FF; in_b = 16'h0F0F; in_tag = 4'hB;
        @(posedge clk);
        @(negedge clk);
        in_tag = 4'hC;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_full: out_valid got %b expected 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sticky_v !== 1'b0 || out_result !== '0 ||
            out_flags !== '0 || out_tag !== '0) begin
            errors++;
            $display("FAIL rst_async: got valid=%b sticky=%b res=%h flags=%b tag=%h expected all zero",
                     out_valid, sticky_v, out_result, out_flags, out_tag);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale[%0d]: out_valid got %b expected 0 (tag=%h)", i, out_valid, out_tag);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
